mult8_seq_ctrl: RTL and testbench
=================================

Name: mult8_seq_ctrl

Overview:
Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing one instance of the team's existing 4x4 combinational array multiplier (array_mult_structural) over up to four partial-product steps. The block accepts operands on a valid/ready input handshake, accumulates shifted nibble products in a 16-bit register, and presents the result on a valid/ready output handshake. It sits between a host register interface and the shared 4x4 multiplier array.

Parameters:
ZERO_SKIP, 0, when 1 skip any step whose operand nibble pair contains a zero nibble (product known 0); when 0 always execute all four steps.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  8  multiplicand (unsigned)
b  input  8  multiplier (unsigned)
out_valid  output  1  result p valid
out_ready  input  1  consumer accepts result
p  output  16  product a*b
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE, accumulator=0, step=0, latched operands=0; outputs in_ready=1, out_valid=0, p=0, busy=0. Reset overrides every other event, including mid-step and during DONE.
- States: IDLE, MUL, DONE. in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready at edge t0: latch a->A, b->B, clear accumulator, compute skip mask, enter MUL at the first enabled step. If every step is skipped (ZERO_SKIP=1 and A==0 or B==0), go directly to DONE with accumulator=0.
- Step order and shift: step0 A[3:0]*B[3:0] <<0; step1 A[7:4]*B[3:0] <<4; step2 A[3:0]*B[7:4] <<4; step3 A[7:4]*B[7:4] <<8.
- MUL: the multiplier m/q inputs are driven combinationally from the latched nibbles selected by step; at the end of the cycle accumulator += zero-extended 8-bit product << shift (16-bit add, overflow impossible since max is 0xFE01). Then advance to the next enabled step, or to DONE after the last enabled step.
- Skip mask (ZERO_SKIP=1 only): step enabled iff both of its nibbles are non-zero. With ZERO_SKIP=0 all four steps are enabled.
- Latency: out_valid first high in cycle t0+1+N, where N is the number of enabled steps (t0+5 when ZERO_SKIP=0).
- DONE: p = accumulator, held stable while out_valid&&!out_ready. On out_valid&&out_ready: go to IDLE; in_ready rises the next cycle. Minimum issue interval is 6 cycles with ZERO_SKIP=0.
- p holds the last result after the handshake until the next accept clears the accumulator. p is meaningful only while out_valid=1.
- a/b changes after accept have no effect. in_valid outside IDLE is ignored (no accept, no queueing).
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, p=0x0000; no accept occurs during reset.
- ZERO_SKIP=0, a=0xFF, b=0xFF, out_ready=1, accept at t0 -> out_valid=1 only in cycle t0+5 with p=0xFE01; busy=1 during t0+1..t0+5; in_ready=1 again at t0+6.
- Backpressure: a=0x12, b=0x34, out_ready=0 for 10 cycles after out_valid -> p=0x03A8 stable, in_ready=0, a new in_valid with a=0x99 is ignored; release out_ready -> exactly one handshake, then IDLE.
- ZERO_SKIP=1: a=0x0F, b=0xF0 -> single step, out_valid at t0+2 with p=0x0E10; a=0x00, b=0x77 -> out_valid at t0+1 with p=0x0000; a=0xFF, b=0xFF -> t0+5, p=0xFE01.
- Reset mid-operation: assert rst during step2 of 0x55*0x55 -> next cycle state IDLE, out_valid=0, p=0; then 0xA5*0x3C -> p=0x26AC at t0+5.
- Exhaustive sweep, both ZERO_SKIP values, random out_ready stalls: all 65536 (a,b) pairs -> p==a*b, and out_valid timing matches t0+1+N.

Source files
------------

// File: rtl/mult8_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mult8_seq_ctrl_if
// Purpose : Handshake bundle between a host and the sequential 8x8 multiplier
//           controller. The operand side and the result side each use their
//           own valid/ready pair.
// Signals :
//   in_valid  host -> ctrl   operands a/b are valid
//   in_ready  ctrl -> host   controller can accept operands (IDLE)
//   a, b      host -> ctrl   8-bit unsigned operands
//   out_valid ctrl -> host   product p is valid (DONE)
//   out_ready host -> ctrl   host accepts the product
//   p         ctrl -> host   16-bit product
//   busy      ctrl -> host   controller is not idle
// Modports: master = host side, slave = controller side.
// ----------------------------------------------------------------------------
interface mult8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mult8_seq_ctrl
// Purpose : Computes an unsigned 8x8 -> 16-bit product by stepping one shared
//           4x4 array multiplier over the four nibble pairs and accumulating
//           the shifted partial products.
// Parameters:
//   ZERO_SKIP  1 = skip any step whose nibble pair contains a zero nibble,
//              0 = always run all four steps.
// Ports   :
//   clk   input   system clock, rising edge
//   rst   input   synchronous active-high reset
//   bus   slave   operand/result handshake (see mult8_seq_ctrl_if)
// ----------------------------------------------------------------------------

// 4x4 unsigned array multiplier: AND rows of the multiplicand gated by each
// multiplier bit, summed with the proper binary weight.
module array_mult_structural (
    input  logic [3:0] i_m,
    input  logic [3:0] i_q,
    output logic [7:0] o_product
);
    logic [3:0] w_pp0;
    logic [3:0] w_pp1;
    logic [3:0] w_pp2;
    logic [3:0] w_pp3;

    assign w_pp0 = i_m & {4{i_q[0]}};
    assign w_pp1 = i_m & {4{i_q[1]}};
    assign w_pp2 = i_m & {4{i_q[2]}};
    assign w_pp3 = i_m & {4{i_q[3]}};

    assign o_product = {4'b0000, w_pp0}
                     + {3'b000, w_pp1, 1'b0}
                     + {2'b00, w_pp2, 2'b00}
                     + {1'b0, w_pp3, 3'b000};
endmodule

module mult8_seq_ctrl #(
    parameter int ZERO_SKIP = 0
) (
    input  logic           clk,
    input  logic           rst,
    mult8_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [7:0]  r_A;
    logic [7:0]  r_B;
    logic [15:0] r_accum;
    logic [1:0]  r_step;
    logic [3:0]  r_stepMask;

    logic [3:0]  w_enMask;
    logic [2:0]  w_firstStep;
    logic [2:0]  w_nextStep;
    logic [3:0]  w_mulM;
    logic [3:0]  w_mulQ;
    logic [7:0]  w_nibProd;
    logic [15:0] w_shiftedProd;

    // Lowest enabled step at or above 'from'. Bit 2 of the result set means
    // no enabled step remains, which is how the caller knows to finish.
    function automatic logic [2:0] findStep(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                res = {1'b0, 2'(i)};
            end
        end
        return res;
    endfunction

    // Step enable mask for the operands being offered. Bit n enables step n:
    // step0 = lo*lo, step1 = Ahi*Blo, step2 = Alo*Bhi, step3 = hi*hi.
    // A step with a zero nibble contributes nothing, so it may be skipped.
    always_comb begin
        w_enMask = 4'b1111;
        if (ZERO_SKIP != 0) begin
            w_enMask[0] = (bus.a[3:0] != 4'd0) && (bus.b[3:0] != 4'd0);
            w_enMask[1] = (bus.a[7:4] != 4'd0) && (bus.b[3:0] != 4'd0);
            w_enMask[2] = (bus.a[3:0] != 4'd0) && (bus.b[7:4] != 4'd0);
            w_enMask[3] = (bus.a[7:4] != 4'd0) && (bus.b[7:4] != 4'd0);
        end
    end

    assign w_firstStep = findStep(w_enMask, 3'd0);
    assign w_nextStep  = findStep(r_stepMask, {1'b0, r_step} + 3'd1);

    // Route the latched nibbles for the current step into the shared array
    // and pick the weight its product carries in the full result.
    always_comb begin
        w_mulM        = r_A[3:0];
        w_mulQ        = r_B[3:0];
        w_shiftedProd = {8'h00, w_nibProd};
        case (r_step)
            2'd0: begin
                w_mulM        = r_A[3:0];
                w_mulQ        = r_B[3:0];
                w_shiftedProd = {8'h00, w_nibProd};
            end
            2'd1: begin
                w_mulM        = r_A[7:4];
                w_mulQ        = r_B[3:0];
                w_shiftedProd = {4'h0, w_nibProd, 4'h0};
            end
            2'd2: begin
                w_mulM        = r_A[3:0];
                w_mulQ        = r_B[7:4];
                w_shiftedProd = {4'h0, w_nibProd, 4'h0};
            end
            default: begin
                w_mulM        = r_A[7:4];
                w_mulQ        = r_B[7:4];
                w_shiftedProd = {w_nibProd, 8'h00};
            end
        endcase
    end

    array_mult_structural u_mult (
        .i_m       (w_mulM),
        .i_q       (w_mulQ),
        .o_product (w_nibProd)
    );

    // State register; reset wins over any handshake or step in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and handshake outputs. The outputs depend on state
    // only, so in_valid/out_ready never reach in_ready/out_valid directly.
    always_comb begin
        w_stateNext   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_stateNext = w_firstStep[2] ? DONE : MUL;
                end
            end
            MUL: begin
                if (w_nextStep[2]) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: latch operands and step plan on accept, then add one shifted
    // partial product per MUL cycle. The accumulator is left alone after the
    // result handshake so p keeps the last product until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_A        <= 8'h00;
            r_B        <= 8'h00;
            r_accum    <= 16'h0000;
            r_step     <= 2'd0;
            r_stepMask <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_A        <= bus.a;
                        r_B        <= bus.b;
                        r_accum    <= 16'h0000;
                        r_step     <= w_firstStep[1:0];
                        r_stepMask <= w_enMask;
                    end
                end
                MUL: begin
                    r_accum <= r_accum + w_shiftedProd;
                    if (!w_nextStep[2]) begin
                        r_step <= w_nextStep[1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.p = r_accum;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mult8_seq_ctrl
// Purpose : Self-checking bench for mult8_seq_ctrl. Two instances run side by
//           side, one with ZERO_SKIP=0 (dut0) and one with ZERO_SKIP=1 (dut1).
//           Expected products and latencies come from plain arithmetic on the
//           operands: p = a*b, result appears 1+N cycles after accept where N
//           is the number of nibble pairs that need a multiply.
// ----------------------------------------------------------------------------
module tb_mult8_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mult8_seq_ctrl_if ifc0 ();
    mult8_seq_ctrl_if ifc1 ();

    mult8_seq_ctrl #(.ZERO_SKIP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    mult8_seq_ctrl #(.ZERO_SKIP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; all driving and sampling happens
    // one time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input int sel, input logic v, input logic [7:0] av,
                         input logic [7:0] bv, input logic ordy);
        if (sel == 0) begin
            ifc0.in_valid  = v;
            ifc0.a         = av;
            ifc0.b         = bv;
            ifc0.out_ready = ordy;
        end else begin
            ifc1.in_valid  = v;
            ifc1.a         = av;
            ifc1.b         = bv;
            ifc1.out_ready = ordy;
        end
    endtask

    // Packed view of one instance's outputs: {busy, out_valid, in_ready, p}.
    function automatic logic [18:0] getOut(input int sel);
        if (sel == 0) begin
            return {ifc0.busy, ifc0.out_valid, ifc0.in_ready, ifc0.p};
        end
        return {ifc1.busy, ifc1.out_valid, ifc1.in_ready, ifc1.p};
    endfunction

    function automatic string tagOf(input int sel, input string name);
        return $sformatf("dut%0d_%s", sel, name);
    endfunction

    // Number of multiply steps the reference expects: all four without
    // zero skipping, otherwise one per nibble pair with no zero nibble.
    function automatic int enabledSteps(input int sel, input logic [7:0] av, input logic [7:0] bv);
        int n;
        logic [7:0] an;
        logic [7:0] bn;
        if (sel == 0) begin
            return 4;
        end
        n = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                an = (av >> (4 * i)) & 8'h0F;
                bn = (bv >> (4 * j)) & 8'h0F;
                if (an != 8'h00 && bn != 8'h00) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    task automatic checkIdle(input int sel, input string name, input logic [15:0] expP);
        logic [18:0] o;
        o = getOut(sel);
        checkOutput(tagOf(sel, {name, "_in_ready"}),  32'(o[16]), 32'd1);
        checkOutput(tagOf(sel, {name, "_out_valid"}), 32'(o[17]), 32'd0);
        checkOutput(tagOf(sel, {name, "_busy"}),      32'(o[18]), 32'd0);
        checkOutput(tagOf(sel, {name, "_p"}),         32'(o[15:0]), 32'(expP));
    endtask

    // One full transaction. fixedStall >= 0 holds out_ready low for that many
    // DONE cycles while hammering in_valid with a=b=0x99; fixedStall < 0 uses
    // random out_ready and random junk on the operand side.
    task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                 input int fixedStall);
        logic [18:0] o;
        logic [15:0] expP;
        int          k;
        int          expLat;
        int          stalls;
        logic        ordy;
        logic        done;

        expP   = 16'(av) * 16'(bv);
        expLat = 1 + enabledSteps(sel, av, bv);

        o = getOut(sel);
        checkOutput(tagOf(sel, "ready_before_accept"), 32'(o[16]), 32'd1);
        setIn(sel, 1'b1, av, bv, 1'b0);
        tick();
        k = 1;
        o = getOut(sel);

        while (!o[17] && k <= 20) begin
            checkOutput(tagOf(sel, "busy_in_mul"),     32'(o[18]), 32'd1);
            checkOutput(tagOf(sel, "in_ready_in_mul"), 32'(o[16]), 32'd0);
            if (fixedStall >= 0) begin
                setIn(sel, 1'b1, 8'h99, 8'h99, 1'b0);
            end else begin
                setIn(sel, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
            end
            tick();
            k++;
            o = getOut(sel);
        end
        if (!o[17]) begin
            checkOutput(tagOf(sel, "result_timeout"), 32'd0, 32'd1);
            setIn(sel, 1'b0, 8'h00, 8'h00, 1'b0);
            return;
        end
        checkOutput(tagOf(sel, $sformatf("latency_%02h_%02h", av, bv)), 32'(k), 32'(expLat));

        stalls = 0;
        done   = 1'b0;
        for (int s = 0; s < 60 && !done; s++) begin
            checkOutput(tagOf(sel, $sformatf("p_%02h_%02h", av, bv)), 32'(o[15:0]), 32'(expP));
            checkOutput(tagOf(sel, "out_valid_held"), 32'(o[17]), 32'd1);
            checkOutput(tagOf(sel, "in_ready_in_done"), 32'(o[16]), 32'd0);
            if (fixedStall >= 0) begin
                ordy = (stalls >= fixedStall);
                setIn(sel, 1'b1, 8'h99, 8'h99, ordy);
            end else begin
                ordy = ($urandom_range(2) == 0);
                setIn(sel, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), ordy);
            end
            tick();
            stalls++;
            o = getOut(sel);
            if (ordy) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checkOutput(tagOf(sel, "handshake_timeout"), 32'd0, 32'd1);
        end
        setIn(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        checkIdle(sel, "after_handshake", expP);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        checks = 0;
        errors = 0;

        // Reset held two cycles with in_valid asserted on both instances.
        rst = 1'b1;
        setIn(0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        setIn(1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkIdle(0, "reset", 16'h0000);
            checkIdle(1, "reset", 16'h0000);
        end
        setIn(0, 1'b0, 8'h00, 8'h00, 1'b0);
        setIn(1, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        checkIdle(0, "post_reset", 16'h0000);
        checkIdle(1, "post_reset", 16'h0000);

        $display("[TB] directed transactions");
        applyStimulus(0, 8'hFF, 8'hFF, 0);
        applyStimulus(0, 8'h12, 8'h34, 10);
        applyStimulus(1, 8'h0F, 8'hF0, -1);
        applyStimulus(1, 8'h00, 8'h77, -1);
        applyStimulus(1, 8'hFF, 8'hFF, -1);
        applyStimulus(1, 8'h12, 8'h34, 10);

        // Reset while 0x55*0x55 is in its third step (step2).
        $display("[TB] reset during multiply");
        setIn(0, 1'b1, 8'h55, 8'h55, 1'b0);
        tick();
        setIn(0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("dut0_busy_before_midreset", 32'(getOut(0) >> 18), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle(0, "midreset", 16'h0000);
        applyStimulus(0, 8'hA5, 8'h3C, -1);

        // Random operands, biased toward zero nibbles to exercise skipping.
        $display("[TB] random transactions");
        for (int n = 0; n < 250; n++) begin
            for (int sel = 0; sel < 2; sel++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                if ($urandom_range(3) == 0) ra[3:0] = 4'h0;
                if ($urandom_range(3) == 0) ra[7:4] = 4'h0;
                if ($urandom_range(3) == 0) rb[3:0] = 4'h0;
                if ($urandom_range(3) == 0) rb[7:4] = 4'h0;
                applyStimulus(sel, ra, rb, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
